// File: rtl/ahblite_busmatrix_outputstage_nport.sv
// AHB-Lite bus-matrix output stage: arbitrates N input stages onto one slave port.
// Optional OUTPUTSTAGE_RR_EN selects round-robin arbitration (default: fixed priority, lowest index).
module ahblite_busmatrix_outputstage_nport #(
    parameter int unsigned NUM_PORTS = 3,
    parameter int unsigned ADDR_W    = 32,
    parameter int unsigned DATA_W    = 32
) (
    input  logic                          HCLK,
    input  logic                          HRESET,
    input  logic [NUM_PORTS-1:0]          HSEL_IN,
    input  logic [NUM_PORTS*ADDR_W-1:0]   HADDR_IN,
    input  logic [NUM_PORTS*2-1:0]        HTRANS_IN,
    input  logic [NUM_PORTS-1:0]          HWRITE_IN,
    input  logic [NUM_PORTS*3-1:0]        HSIZE_IN,
    input  logic [NUM_PORTS*3-1:0]        HBURST_IN,
    input  logic [NUM_PORTS*4-1:0]        HPROT_IN,
    input  logic [NUM_PORTS*DATA_W-1:0]   HWDATA_IN,
    input  logic [NUM_PORTS-1:0]          TRANS_HOLD_IN,
    input  logic                          HREADYOUT,
    output logic [NUM_PORTS-1:0]          ACTIVE,
    output logic                          HSEL,
    output logic [ADDR_W-1:0]             HADDR,
    output logic [1:0]                    HTRANS,
    output logic                          HWRITE,
    output logic [2:0]                    HSIZE,
    output logic [2:0]                    HBURST,
    output logic [3:0]                    HPROT,
    output logic                          HREADY,
    output logic [DATA_W-1:0]             HWDATA
);

    localparam int unsigned OWN_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
    localparam int unsigned NSLOT = 1 << OWN_W;

    logic               r_owner_vld;
    logic [OWN_W-1:0]   r_owner;
    logic [OWN_W-1:0]   r_last;
    logic               r_data_vld;
    logic [OWN_W-1:0]   r_data_port;

    logic [NSLOT-1:0]   w_req;
    logic [NSLOT-1:0]   w_sel;
    logic [ADDR_W-1:0]  w_addr  [NSLOT];
    logic [1:0]         w_trans [NSLOT];
    logic [NSLOT-1:0]   w_write;
    logic [2:0]         w_size  [NSLOT];
    logic [2:0]         w_burst [NSLOT];
    logic [3:0]         w_prot  [NSLOT];
    logic [DATA_W-1:0]  w_wdata [NSLOT];

    logic               w_lock;
    logic               w_found;
    logic [OWN_W-1:0]   w_pick;

    // Unpack flat per-port buses into power-of-two slots; unused slots never request.
    for (genvar g = 0; g < NSLOT; g++) begin : g_slot
        if (g < NUM_PORTS) begin : g_port
            assign w_req[g]   = HSEL_IN[g] & TRANS_HOLD_IN[g];
            assign w_sel[g]   = HSEL_IN[g];
            assign w_addr[g]  = HADDR_IN[g*ADDR_W +: ADDR_W];
            assign w_trans[g] = HTRANS_IN[g*2 +: 2];
            assign w_write[g] = HWRITE_IN[g];
            assign w_size[g]  = HSIZE_IN[g*3 +: 3];
            assign w_burst[g] = HBURST_IN[g*3 +: 3];
            assign w_prot[g]  = HPROT_IN[g*4 +: 4];
            assign w_wdata[g] = HWDATA_IN[g*DATA_W +: DATA_W];
        end else begin : g_pad
            assign w_req[g]   = 1'b0;
            assign w_sel[g]   = 1'b0;
            assign w_addr[g]  = '0;
            assign w_trans[g] = '0;
            assign w_write[g] = 1'b0;
            assign w_size[g]  = '0;
            assign w_burst[g] = '0;
            assign w_prot[g]  = '0;
            assign w_wdata[g] = '0;
        end
    end

    // Address/control mux from the current address-phase owner.
    always_comb begin
        HSEL   = 1'b0;
        HADDR  = '0;
        HTRANS = 2'b00;
        HWRITE = 1'b0;
        HSIZE  = 3'b000;
        HBURST = 3'b000;
        HPROT  = 4'b0000;
        if (r_owner_vld) begin
            HSEL   = w_sel[r_owner];
            HADDR  = w_addr[r_owner];
            HTRANS = w_trans[r_owner];
            HWRITE = w_write[r_owner];
            HSIZE  = w_size[r_owner];
            HBURST = w_burst[r_owner];
            HPROT  = w_prot[r_owner];
        end
    end

    always_comb begin
        ACTIVE = '0;
        for (int unsigned i = 0; i < NUM_PORTS; i++) begin
            ACTIVE[i] = r_owner_vld & (r_owner == OWN_W'(i));
        end
    end

    assign HREADY = r_data_vld ? HREADYOUT : 1'b1;
    assign HWDATA = r_data_vld ? w_wdata[r_data_port] : '0;

    // A live burst keeps its grant while the owner still requests.
    assign w_lock = r_owner_vld & w_req[r_owner] & (HBURST != 3'b000) & (HTRANS != 2'b00);

    always_comb begin
        w_found = 1'b0;
        w_pick  = '0;
`ifdef OUTPUTSTAGE_RR_EN
        for (int unsigned k = 1; k <= NUM_PORTS; k++) begin
            int unsigned idx;
            idx = (32'(r_last) + k) % NUM_PORTS;
            if (!w_found && w_req[OWN_W'(idx)]) begin
                w_found = 1'b1;
                w_pick  = OWN_W'(idx);
            end
        end
`else
        for (int unsigned k = 0; k < NUM_PORTS; k++) begin
            if (!w_found && w_req[k]) begin
                w_found = 1'b1;
                w_pick  = OWN_W'(k);
            end
        end
`endif
    end

    // Owner and data-phase tracking; everything freezes while HREADY is low.
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            r_owner_vld <= 1'b0;
            r_owner     <= '0;
            r_last      <= OWN_W'(NUM_PORTS - 1);
            r_data_vld  <= 1'b0;
            r_data_port <= '0;
        end else if (HREADY) begin
            if (!w_lock) begin
                r_owner_vld <= w_found;
                if (w_found) begin
                    r_owner <= w_pick;
                    r_last  <= w_pick;
                end
            end
            r_data_vld  <= HSEL & HTRANS[1];
            r_data_port <= r_owner;
        end
    end

endmodule
